uart_dmem_loader: RTL and testbench

UART_DMEM_LOADER -- requirements
Module: uart_dmem_loader

---
 rtl/uart_dmem_loader.sv | 153 +++++++++++++++
 tb/tb_uart_dmem_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_dmem_loader.sv
`timescale 1ns/1ps
// Assembles UART bytes into little-endian 32-bit words and writes them
// into the data RAM, ending the session on a full RAM or an idle timeout.
module uart_dmem_loader #(
    parameter int WORD_COUNT   = 16384,
    parameter int IDLE_TIMEOUT = 100000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_byte_i,
    output logic        upg_wen_o,
    output logic [13:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        busy_o,
    output logic [14:0] word_cnt_o,
    output logic        overflow_o
);

    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_asm;
    logic [1:0]    r_k;
    logic [TW-1:0] r_tmo;
    logic          r_seen;
    logic          r_last;
    logic [14:0]   r_wcnt;
    logic [13:0]   r_adr;
    logic [31:0]   r_dat;
    logic          r_ovf;

    logic          w_start;
    logic          w_word;
    logic          w_expire;
    logic          w_full;
    logic [14:0]   w_cnt_inc;

    always_comb begin
        w_start   = start_i && (r_state == S_IDLE || r_state == S_DONE);
        w_word    = (r_state == S_LOAD) && rx_valid_i && (r_k == 2'd3);
        // A byte in the expiry cycle wins, so expiry requires no strobe
        w_expire  = (r_state == S_LOAD) && r_seen && !rx_valid_i &&
                    (r_tmo == TW'(IDLE_TIMEOUT - 1));
        w_cnt_inc = r_wcnt + 15'd1;
        w_full    = (w_cnt_inc == 15'(WORD_COUNT));
        w_next    = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start_i) w_next = S_LOAD;
            end
            S_LOAD: begin
                if (w_word)
                    w_next = S_WRITE;
                else if (w_expire)
                    w_next = (r_k != 2'd0) ? S_WRITE : S_DONE;
            end
            S_WRITE: begin
                w_next = (r_last || w_full) ? S_DONE : S_LOAD;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_asm  <= '0;
            r_k    <= '0;
            r_tmo  <= '0;
            r_seen <= 1'b0;
            r_last <= 1'b0;
            r_wcnt <= '0;
            r_adr  <= '0;
            r_dat  <= '0;
            r_ovf  <= 1'b0;
        end else if (w_start) begin
            r_asm  <= '0;
            r_k    <= '0;
            r_tmo  <= '0;
            r_seen <= 1'b0;
            r_last <= 1'b0;
            r_wcnt <= '0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (rx_valid_i) begin
                        r_tmo  <= '0;
                        r_seen <= 1'b1;
                        if (r_k == 2'd3) begin
                            r_dat <= {rx_byte_i, r_asm[23:0]};
                            r_adr <= r_wcnt[13:0];
                            r_asm <= '0;
                            r_k   <= '0;
                        end else begin
                            r_asm[{r_k, 3'b000} +: 8] <= rx_byte_i;
                            r_k <= r_k + 2'd1;
                        end
                    end else if (w_expire) begin
                        r_tmo <= '0;
                        // Unfilled lanes are already zero after each word
                        if (r_k != 2'd0) begin
                            r_dat  <= r_asm;
                            r_adr  <= r_wcnt[13:0];
                            r_asm  <= '0;
                            r_k    <= '0;
                            r_last <= 1'b1;
                        end
                    end else if (r_seen) begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_WRITE: begin
                    r_wcnt <= w_cnt_inc;
                    if (rx_valid_i) begin
                        r_asm[7:0] <= rx_byte_i;
                        r_k        <= 2'd1;
                        r_tmo      <= '0;
                    end
                end
                S_DONE: begin
                    if (rx_valid_i && r_wcnt == 15'(WORD_COUNT))
                        r_ovf <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign upg_wen_o  = (r_state == S_WRITE);
    assign upg_done_o = (r_state == S_DONE);
    assign busy_o     = (r_state == S_LOAD) || (r_state == S_WRITE);
    assign upg_adr_o  = r_adr;
    assign upg_dat_o  = r_dat;
    assign word_cnt_o = r_wcnt;
    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_uart_dmem_loader.sv
`timescale 1ns/1ps
// Bench for uart_dmem_loader: table of single-word sessions plus
// hand sequences; RAM writes are checked against an expected-write queue.
module tb_uart_dmem_loader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_i = 1'b0;
    logic        rx_valid_i = 1'b0;
    logic [7:0]  rx_byte_i = '0;
    logic        upg_wen_o;
    logic [13:0] upg_adr_o;
    logic [31:0] upg_dat_o;
    logic        upg_done_o;
    logic        busy_o;
    logic [14:0] word_cnt_o;
    logic        overflow_o;

    always #5 clock = ~clock;

    uart_dmem_loader #(
        .WORD_COUNT   (4),
        .IDLE_TIMEOUT (8)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start_i    (start_i),
        .rx_valid_i (rx_valid_i),
        .rx_byte_i  (rx_byte_i),
        .upg_wen_o  (upg_wen_o),
        .upg_adr_o  (upg_adr_o),
        .upg_dat_o  (upg_dat_o),
        .upg_done_o (upg_done_o),
        .busy_o     (busy_o),
        .word_cnt_o (word_cnt_o),
        .overflow_o (overflow_o)
    );

    typedef struct packed {
        logic [13:0] adr;
        logic [31:0] dat;
    } wr_t;

    typedef struct {
        int          n;
        logic [31:0] bytes;
        logic [31:0] exp;
    } vec_t;

    wr_t  exp_q[$];
    vec_t tbl[4];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        wr_t e;
        if (upg_wen_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: adr %0d dat 0x%08h, none expected",
                         upg_adr_o, upg_dat_o);
            end else begin
                e = exp_q.pop_front();
                chk("wr_adr", 32'(upg_adr_o), 32'(e.adr));
                chk("wr_dat", upg_dat_o, e.dat);
                chk("wr_busy", 32'(busy_o), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte_i  = b;
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (upg_done_o) break;
            tick();
        end
        chk("done_reached", 32'(upg_done_o), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4, 32'h44332211, 32'h44332211};
        tbl[1] = '{2, 32'hDEADBBAA, 32'h0000BBAA};
        tbl[2] = '{1, 32'h1234565A, 32'h0000005A};
        tbl[3] = '{3, 32'h99C3B2A1, 32'h00C3B2A1};

        #12;
        chk("rst_wen", 32'(upg_wen_o), 32'd0);
        chk("rst_done", 32'(upg_done_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_cnt", 32'(word_cnt_o), 32'd0);
        chk("rst_adr_dat", 32'(upg_adr_o) | upg_dat_o, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Single-word sessions, each ended by idle timeout
        for (int i = 0; i < 4; i++) begin
            pulse_start();
            chk("start_busy", 32'(busy_o), 32'd1);
            chk("start_done", 32'(upg_done_o), 32'd0);
            chk("start_cnt", 32'(word_cnt_o), 32'd0);
            exp_q.push_back('{14'd0, tbl[i].exp});
            for (int j = 0; j < tbl[i].n; j++)
                send(tbl[i].bytes[8*j +: 8]);
            wait_done();
            chk("tbl_cnt", 32'(word_cnt_o), 32'd1);
            chk("tbl_busy", 32'(busy_o), 32'd0);
            chk("tbl_ovf", 32'(overflow_o), 32'd0);
            chk("tbl_pending", 32'(exp_q.size()), 32'd0);
        end

        // Byte in the would-be expiry cycle keeps the word alive
        pulse_start();
        exp_q.push_back('{14'd0, 32'h04030201});
        send(8'h01);
        repeat (7) tick();
        send(8'h02);
        send(8'h03);
        send(8'h04);
        wait_done();
        chk("prio_cnt", 32'(word_cnt_o), 32'd1);
        chk("prio_pending", 32'(exp_q.size()), 32'd0);

        // No timeout before the first byte
        pulse_start();
        repeat (20) tick();
        chk("nobyte_busy", 32'(busy_o), 32'd1);
        chk("nobyte_done", 32'(upg_done_o), 32'd0);
        exp_q.push_back('{14'd0, 32'hD4C3B2A1});
        send(8'hA1);
        send(8'hB2);
        send(8'hC3);
        send(8'hD4);
        wait_done();
        chk("nobyte_cnt", 32'(word_cnt_o), 32'd1);
        chk("nobyte_pending", 32'(exp_q.size()), 32'd0);

        // Back-to-back stream fills the RAM, bytes land in WRITE cycles
        pulse_start();
        for (int w = 0; w < 4; w++)
            exp_q.push_back('{14'(w), 32'h03020100 + 32'(w) * 32'h04040404});
        for (int b = 0; b < 16; b++)
            send(8'(b));
        wait_done();
        chk("full_cnt", 32'(word_cnt_o), 32'd4);
        chk("full_ovf_pre", 32'(overflow_o), 32'd0);
        chk("full_pending", 32'(exp_q.size()), 32'd0);
        send(8'hFF);
        chk("full_ovf", 32'(overflow_o), 32'd1);
        chk("full_done_hold", 32'(upg_done_o), 32'd1);

        pulse_start();
        chk("restart_ovf", 32'(overflow_o), 32'd0);
        chk("restart_done", 32'(upg_done_o), 32'd0);
        chk("restart_cnt", 32'(word_cnt_o), 32'd0);
        chk("restart_busy", 32'(busy_o), 32'd1);

        // Asynchronous reset mid-word
        send(8'h55);
        send(8'h66);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_wen", 32'(upg_wen_o), 32'd0);
        chk("arst_adr", 32'(upg_adr_o), 32'd0);
        chk("arst_dat", upg_dat_o, 32'd0);
        chk("arst_done", 32'(upg_done_o), 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_cnt", 32'(word_cnt_o), 32'd0);
        chk("arst_ovf", 32'(overflow_o), 32'd0);
        tick();
        reset_n = 1'b1;
        send(8'h10);
        send(8'h20);
        send(8'h30);
        send(8'h40);
        repeat (20) tick();
        chk("post_rst_busy", 32'(busy_o), 32'd0);
        chk("post_rst_done", 32'(upg_done_o), 32'd0);
        chk("post_rst_cnt", 32'(word_cnt_o), 32'd0);
        pulse_start();
        chk("post_rst_start", 32'(busy_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
